// File: rtl/matriz_scan_decoder_pkg.sv
// Shared definitions for the 5x7 matrix scan decoder: geometry, FSM encodings
// and the frame-index helper used by both the driver and decoder sides.
package matriz_scan_decoder_pkg;

    localparam int ROWS    = 5;
    localparam int COLS    = 7;
    localparam int FRAME_W = ROWS * COLS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        HELD  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_ONE   = 2'd1,
        CLS_MULTI = 2'd2
    } row_cls_e;

    // Bit position of LED (row r, column c) inside the packed frame.
    function automatic int unsigned pix_idx(input int unsigned r, input int unsigned c);
        return r * COLS + c;
    endfunction

    function automatic logic [2:0] onehot_idx(input logic [ROWS-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/matriz_scan_decoder_if.sv
// Pin-side and frame-side signals of the scan decoder, grouped for port lists.
interface matriz_scan_decoder_if;
    import matriz_scan_decoder_pkg::*;

    logic [ROWS-1:0]    L;
    logic [COLS-1:0]    C;
    logic [FRAME_W-1:0] frame;
    logic               frame_valid;
    logic               frame_changed;
    logic [15:0]        change_cnt;
    logic               row_err;
    logic               scan_lost;

    modport master (
        output L, C,
        input  frame, frame_valid, frame_changed, change_cnt, row_err, scan_lost
    );

    modport slave (
        input  L, C,
        output frame, frame_valid, frame_changed, change_cnt, row_err, scan_lost
    );

endinterface

// File: rtl/matriz_scan_decoder_sync2.sv
// Two-flop synchronizer for a bus of independently sampled asynchronous lines.
module matriz_scan_decoder_sync2 #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/matriz_scan_decoder.sv
// Rebuilds the 35-pixel frame from the multiplexed row/column lines of a 5x7
// LED matrix and publishes one frame per completed scan.
module matriz_scan_decoder
    import matriz_scan_decoder_pkg::*;
#(
    parameter logic ROW_ACT   = 1'b1,
    parameter logic COL_ACT   = 1'b1,
    parameter int   MIN_DWELL = 4,
    parameter int   TIMEOUT   = 4096
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    matriz_scan_decoder_if.slave   bus
);

    localparam logic [15:0] TO_CNT    = 16'(TIMEOUT);
    localparam logic [7:0]  DWELL_CNT = 8'(MIN_DWELL);

    logic [ROWS-1:0]    l_sync;
    logic [COLS-1:0]    c_sync;
    logic [ROWS-1:0]    l_act;
    logic [COLS-1:0]    c_act;
    row_cls_e           cls;
    logic [2:0]         r_idx;

    state_e             state_q, state_d;
    logic [2:0]         row_q, row_d;
    logic [7:0]         dwell_q, dwell_d;
    logic [15:0]        idle_q, idle_d;
    logic [COLS-1:0]    c_prev_q;
    logic               cap;

    logic [ROWS-1:0]    mask_q, mask_d;
    logic [FRAME_W-1:0] buf_q, buf_d;
    logic [FRAME_W-1:0] frame_q;
    logic               fv_q, fc_q, err_q, lost_q;
    logic [15:0]        cnt_q;
    logic               pub, changed;

    // Synchronizers reset to the idle line level so the first sampled cycle reads as NONE.
    matriz_scan_decoder_sync2 #(.W(ROWS), .RST_VAL({ROWS{~ROW_ACT}})) u_sync_l (
        .clk_i (CLK), .rst_ni (RST_N), .d_i (bus.L), .q_o (l_sync)
    );

    matriz_scan_decoder_sync2 #(.W(COLS), .RST_VAL({COLS{~COL_ACT}})) u_sync_c (
        .clk_i (CLK), .rst_ni (RST_N), .d_i (bus.C), .q_o (c_sync)
    );

    assign l_act = l_sync ^ {ROWS{~ROW_ACT}};
    assign c_act = c_sync ^ {COLS{~COL_ACT}};
    assign r_idx = onehot_idx(l_act);

    always_comb begin
        if (l_act == '0)          cls = CLS_NONE;
        else if ($onehot(l_act))  cls = CLS_ONE;
        else                      cls = CLS_MULTI;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            row_q    <= '0;
            dwell_q  <= '0;
            idle_q   <= '0;
            c_prev_q <= '0;
            err_q    <= 1'b0;
            lost_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            dwell_q  <= dwell_d;
            idle_q   <= idle_d;
            c_prev_q <= c_act;
            err_q    <= err_q | (cls == CLS_MULTI);
            lost_q   <= (idle_d == TO_CNT);
            if (pub && changed) cnt_q <= cnt_q + 16'd1;
        end
    end

    // A capture fires on the cycle the dwell count reaches MIN_DWELL, including on entry.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        dwell_d = dwell_q;
        cap     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cls == CLS_ONE) begin
                    state_d = DWELL;
                    row_d   = r_idx;
                    dwell_d = 8'd1;
                end
            end
            DWELL: begin
                if (cls != CLS_ONE) begin
                    state_d = IDLE;
                end else if (r_idx != row_q) begin
                    row_d   = r_idx;
                    dwell_d = 8'd1;
                end else if (c_act != c_prev_q) begin
                    dwell_d = 8'd1;
                end else begin
                    dwell_d = dwell_q + 8'd1;
                end
            end
            HELD: begin
                if (cls != CLS_ONE) begin
                    state_d = IDLE;
                end else if (r_idx != row_q) begin
                    state_d = DWELL;
                    row_d   = r_idx;
                    dwell_d = 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == DWELL && dwell_d == DWELL_CNT) begin
            cap     = 1'b1;
            state_d = HELD;
        end
    end

    // Publish reads the pre-capture buffer, so a same-cycle capture seeds the next frame.
    always_comb begin
        pub     = (mask_q == '1);
        changed = (buf_q != frame_q);
        idle_d  = (cls == CLS_ONE) ? 16'd0 :
                  (idle_q == TO_CNT) ? TO_CNT : idle_q + 16'd1;
        mask_d  = mask_q;
        buf_d   = buf_q;
        if (pub || idle_d == TO_CNT) mask_d = '0;
        if (cap) begin
            buf_d[pix_idx(32'(row_d), 0) +: COLS] = c_act;
            mask_d[row_d] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mask_q  <= '0;
            buf_q   <= '0;
            frame_q <= '0;
            fv_q    <= 1'b0;
            fc_q    <= 1'b0;
        end else begin
            mask_q <= mask_d;
            buf_q  <= buf_d;
            fv_q   <= pub;
            fc_q   <= pub && changed;
            if (pub) frame_q <= buf_q;
        end
    end

    assign bus.frame         = frame_q;
    assign bus.frame_valid   = fv_q;
    assign bus.frame_changed = fc_q;
    assign bus.change_cnt    = cnt_q;
    assign bus.row_err       = err_q;
    assign bus.scan_lost     = lost_q;

endmodule

// File: tb/tb_matriz_scan_decoder.sv
// Scoreboard bench: two decoders (active-high and active-low pins) fed the same scans.
module tb_matriz_scan_decoder;
    import matriz_scan_decoder_pkg::*;

    localparam int TO = 4096;

    typedef struct {
        logic [34:0] f;
        logic        chg;
        logic [15:0] cnt;
    } exp_t;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    matriz_scan_decoder_if bus1();
    matriz_scan_decoder_if bus2();

    matriz_scan_decoder #(.ROW_ACT(1'b1), .COL_ACT(1'b1), .MIN_DWELL(4), .TIMEOUT(TO)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .bus(bus1.slave)
    );

    matriz_scan_decoder #(.ROW_ACT(1'b0), .COL_ACT(1'b0), .MIN_DWELL(4), .TIMEOUT(TO)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .bus(bus2.slave)
    );

    exp_t        q1[$];
    exp_t        q2[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [34:0] prev_f;
    logic [15:0] exp_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [34:0] pack5(input logic [6:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    task automatic expect_frame(input logic [34:0] f);
        exp_t e;
        e.chg = (f != prev_f);
        if (e.chg) exp_cnt = exp_cnt + 16'd1;
        e.f   = f;
        e.cnt = exp_cnt;
        prev_f = f;
        q1.push_back(e);
        q2.push_back(e);
    endtask

    task automatic drive(input logic [4:0] l, input logic [6:0] c, input int n);
        bus1.L = l;
        bus1.C = c;
        bus2.L = ~l;
        bus2.C = ~c;
        repeat (n) @(negedge CLK);
    endtask

    task automatic row(input int r, input logic [6:0] c, input int n);
        drive(5'(1 << r), c, n);
    endtask

    task automatic scan(input logic [6:0] d0, d1, d2, d3, d4);
        row(0, d0, 10); row(1, d1, 10); row(2, d2, 10); row(3, d3, 10); row(4, d4, 10);
        drive(5'h00, 7'h00, 6);
    endtask

    task automatic mon_check(input int inst, input logic [34:0] f, input logic chg,
                             input logic [15:0] cnt);
        exp_t e;
        logic got;
        got = 1'b0;
        if (inst == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
        if (inst == 2 && q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
        if (!got) begin
            check($sformatf("unexpected_frame_valid_dut%0d", inst), 64'd1, 64'd0);
        end else begin
            check($sformatf("frame_dut%0d", inst), 64'(f), 64'(e.f));
            check($sformatf("frame_changed_dut%0d", inst), 64'(chg), 64'(e.chg));
            check($sformatf("change_cnt_dut%0d", inst), 64'(cnt), 64'(e.cnt));
        end
    endtask

    always @(negedge CLK) begin
        if (RST_N === 1'b1 && bus1.frame_valid === 1'b1)
            mon_check(1, bus1.frame, bus1.frame_changed, bus1.change_cnt);
        if (RST_N === 1'b1 && bus2.frame_valid === 1'b1)
            mon_check(2, bus2.frame, bus2.frame_changed, bus2.change_cnt);
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_dut1"}, 64'({bus1.frame, bus1.frame_valid, bus1.frame_changed,
                                   bus1.change_cnt, bus1.row_err, bus1.scan_lost}), 64'd0);
        check({tag, "_dut2"}, 64'({bus2.frame, bus2.frame_valid, bus2.frame_changed,
                                   bus2.change_cnt, bus2.row_err, bus2.scan_lost}), 64'd0);
    endtask

    initial begin
        RST_N   = 1'b0;
        prev_f  = '0;
        exp_cnt = '0;
        for (int i = 0; i < 5; i++) drive(5'($urandom), 7'($urandom), 1);
        check_zero_outputs("reset_outputs");
        drive(5'h00, 7'h00, 1);
        RST_N = 1'b1;
        drive(5'h00, 7'h00, 8);
        check("post_reset_valid", 64'(bus1.frame_valid), 64'd0);

        // Clean scan, identical repeat, then a shifted pattern.
        expect_frame(pack5(7'h41, 7'h22, 7'h14, 7'h22, 7'h41));
        scan(7'h41, 7'h22, 7'h14, 7'h22, 7'h41);
        expect_frame(pack5(7'h41, 7'h22, 7'h14, 7'h22, 7'h41));
        scan(7'h41, 7'h22, 7'h14, 7'h22, 7'h41);
        expect_frame(pack5(7'h20, 7'h10, 7'h08, 7'h04, 7'h02));
        scan(7'h20, 7'h10, 7'h08, 7'h04, 7'h02);

        // Short dwell and flickering columns on row 5 must not complete the frame.
        row(0, 7'h7F, 10); row(1, 7'h00, 10); row(2, 7'h2A, 10); row(3, 7'h55, 10);
        drive(5'h10, 7'h33, 3);
        drive(5'h00, 7'h00, 4);
        for (int i = 0; i < 10; i++) drive(5'h10, (i % 2) ? 7'h55 : 7'h2A, 1);
        drive(5'h00, 7'h00, 4);
        expect_frame(pack5(7'h7F, 7'h00, 7'h2A, 7'h55, 7'h11));
        row(4, 7'h11, 10);
        drive(5'h00, 7'h00, 6);
        check("row_err_clean_dut1", 64'(bus1.row_err), 64'd0);
        check("row_err_clean_dut2", 64'(bus2.row_err), 64'd0);

        // Multi-hot rows, then a timeout that drops a partial frame.
        drive(5'b00011, 7'h7F, 3);
        drive(5'h00, 7'h00, 3);
        check("row_err_dut1", 64'(bus1.row_err), 64'd1);
        check("row_err_dut2", 64'(bus2.row_err), 64'd1);
        row(0, 7'h01, 10); row(1, 7'h02, 10);
        drive(5'h00, 7'h00, TO - 20);
        check("scan_lost_early", 64'(bus1.scan_lost), 64'd0);
        drive(5'h00, 7'h00, 40);
        check("scan_lost_dut1", 64'(bus1.scan_lost), 64'd1);
        check("scan_lost_dut2", 64'(bus2.scan_lost), 64'd1);
        check("frame_kept", 64'(bus1.frame), 64'(prev_f));
        check("row_err_sticky", 64'(bus1.row_err), 64'd1);
        row(2, 7'h04, 5);
        check("scan_lost_fall_dut1", 64'(bus1.scan_lost), 64'd0);
        check("scan_lost_fall_dut2", 64'(bus2.scan_lost), 64'd0);
        drive(5'h04, 7'h04, 5);
        row(3, 7'h08, 10); row(4, 7'h10, 10);
        expect_frame(pack5(7'h03, 7'h06, 7'h04, 7'h08, 7'h10));
        row(0, 7'h03, 10); row(1, 7'h06, 10);
        drive(5'h00, 7'h00, 6);

        // Reset mid-frame discards the partial scan.
        row(0, 7'h7F, 10); row(1, 7'h7F, 10);
        RST_N = 1'b0;
        drive(5'h00, 7'h00, 2);
        check_zero_outputs("midreset_outputs");
        RST_N = 1'b1;
        prev_f  = '0;
        exp_cnt = '0;
        drive(5'h00, 7'h00, 4);
        row(2, 7'h01, 10); row(3, 7'h01, 10); row(4, 7'h01, 10);
        expect_frame(pack5(7'h01, 7'h01, 7'h01, 7'h01, 7'h01));
        row(0, 7'h01, 10); row(1, 7'h01, 10);
        drive(5'h00, 7'h00, 6);

        for (int i = 0; i < 50 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge CLK);
        check("pending_dut1", 64'(q1.size()), 64'd0);
        check("pending_dut2", 64'(q2.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
